// File: rtl/led_frame_scanner.sv
// Panel refresh sequencer: streams top/bottom pixel pairs from frame RAM to the LED PHY,
// then blanks, latches and row-addresses the panel. Define LED_SCAN_DOUBLE_BUFFER_EN for double buffering.
module led_frame_scanner #(
   parameter int NUM_ROWS      = 32,
   parameter int NUM_COLS      = 64,
   parameter int RAM_ADDR_W    = 16,
   parameter int RAM_LATENCY   = 2,
   parameter int LATCH_CYCLES  = 2,
   parameter int MIN_ON_CYCLES = 256
) (
   input  logic                          clk_in,
   input  logic                          n_reset_in,
   input  logic                          enable_in,
`ifdef LED_SCAN_DOUBLE_BUFFER_EN
   input  logic                          swap_req_in,
   output logic                          active_buf_out,
`endif
   output logic                          busy_out,
   output logic                          frame_done_out,
   output logic                          ram_en_out,
   output logic [RAM_ADDR_W-1:0]         ram_addr_out,
   input  logic [23:0]                   ram_data_in,
   output logic                          phy_enable_out,
   input  logic                          phy_ready_in,
   output logic [23:0]                   phy_pixel_top_out,
   output logic [23:0]                   phy_pixel_bot_out,
   output logic                          le_out,
   output logic                          oe_out,
   output logic [$clog2(NUM_ROWS/2)-1:0] addr_out
);

   localparam int HALF    = NUM_ROWS / 2;
   localparam int ROW_W   = $clog2(HALF);
   localparam int COL_W   = $clog2(NUM_COLS);
   localparam int ON_W    = $clog2(MIN_ON_CYCLES + 1);
   localparam int CYC_MAX = (RAM_LATENCY + 2 > LATCH_CYCLES) ? RAM_LATENCY + 2 : LATCH_CYCLES;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_SEND, S_WAIT_PHY, S_HOLD, S_BLANK, S_LATCH, S_UNBLANK
   } state_t;

   state_t                state, next_state;
   logic [ROW_W-1:0]      row;
   logic [COL_W-1:0]      col;
   logic [CYC_W-1:0]      cyc_cnt;
   logic [ON_W-1:0]       on_cnt;
   logic                  last_row, last_col, frame_end;
   int unsigned           base_addr;
   logic [RAM_ADDR_W-1:0] top_addr, bot_addr;

   assign last_row  = (row == ROW_W'(HALF - 1));
   assign last_col  = (col == COL_W'(NUM_COLS - 1));
   assign frame_end = (state == S_UNBLANK) && last_row;
   assign busy_out  = (state != S_IDLE);

   assign top_addr = RAM_ADDR_W'(base_addr + 32'(row) * 32'(NUM_COLS) + 32'(col));
   assign bot_addr = RAM_ADDR_W'(base_addr + (32'(row) + 32'(HALF)) * 32'(NUM_COLS) + 32'(col));

   always_comb begin
      next_state     = state;
      ram_en_out     = 1'b0;
      ram_addr_out   = '0;
      phy_enable_out = 1'b0;
      case (state)
         S_IDLE:     if (enable_in) next_state = S_READ;
         S_READ: begin
            if (cyc_cnt == CYC_W'(0)) begin
               ram_en_out   = 1'b1;
               ram_addr_out = top_addr;
            end else if (cyc_cnt == CYC_W'(1)) begin
               ram_en_out   = 1'b1;
               ram_addr_out = bot_addr;
            end
            if (cyc_cnt == CYC_W'(RAM_LATENCY + 1)) next_state = S_SEND;
         end
         S_SEND: begin
            if (phy_ready_in) begin
               phy_enable_out = 1'b1;
               next_state     = S_WAIT_PHY;
            end
         end
         // The PHY may still show ready in the cycle right after the start pulse.
         S_WAIT_PHY: if (cyc_cnt != '0 && phy_ready_in) next_state = last_col ? S_HOLD : S_READ;
         S_HOLD:     if (on_cnt >= ON_W'(MIN_ON_CYCLES)) next_state = S_BLANK;
         S_BLANK:    next_state = S_LATCH;
         S_LATCH:    if (cyc_cnt == CYC_W'(LATCH_CYCLES - 1)) next_state = S_UNBLANK;
         S_UNBLANK:  next_state = (last_row && !enable_in) ? S_IDLE : S_READ;
         default:    next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!n_reset_in) begin
         state             <= S_IDLE;
         row               <= '0;
         col               <= '0;
         cyc_cnt           <= '0;
         on_cnt            <= ON_W'(MIN_ON_CYCLES);
         phy_pixel_top_out <= '0;
         phy_pixel_bot_out <= '0;
         le_out            <= 1'b0;
         oe_out            <= 1'b1;
         addr_out          <= '0;
         frame_done_out    <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state != state) cyc_cnt <= '0;
         else if (cyc_cnt != CYC_W'(CYC_MAX)) cyc_cnt <= cyc_cnt + CYC_W'(1);

         // Saturated while idle so the first latch of a scan never waits.
         if (state == S_IDLE) on_cnt <= ON_W'(MIN_ON_CYCLES);
         else if (state == S_UNBLANK) on_cnt <= '0;
         else if (on_cnt < ON_W'(MIN_ON_CYCLES)) on_cnt <= on_cnt + ON_W'(1);

         if (state == S_READ && cyc_cnt == CYC_W'(RAM_LATENCY)) phy_pixel_top_out <= ram_data_in;
         if (state == S_READ && cyc_cnt == CYC_W'(RAM_LATENCY + 1)) phy_pixel_bot_out <= ram_data_in;

         if (state == S_WAIT_PHY && next_state != S_WAIT_PHY) col <= last_col ? '0 : col + COL_W'(1);
         if (state == S_UNBLANK) row <= last_row ? '0 : row + ROW_W'(1);
         if (state == S_BLANK) addr_out <= row;

         le_out         <= (next_state == S_LATCH);
         oe_out         <= (next_state inside {S_IDLE, S_BLANK, S_LATCH});
         frame_done_out <= frame_end;
      end
   end

`ifdef LED_SCAN_DOUBLE_BUFFER_EN
   logic swap_pending;

   assign base_addr = active_buf_out ? 32'(NUM_ROWS * NUM_COLS) : 32'd0;

   // A request landing on the frame boundary itself is kept for the following frame.
   always_ff @(posedge clk_in) begin
      if (!n_reset_in) begin
         active_buf_out <= 1'b0;
         swap_pending   <= 1'b0;
      end else if (frame_end) begin
         if (swap_pending) active_buf_out <= ~active_buf_out;
         swap_pending <= swap_req_in;
      end else if (swap_req_in) begin
         swap_pending <= 1'b1;
      end
   end
`else
   assign base_addr = 32'd0;
`endif

endmodule
